// File: rtl/issue_port_arbiter.sv
// Round-robin arbiter sharing one functional-unit issue port between NUM_RS reservation stations.
// Define ISSUE_ARB_STARVE_EN to add per-station starvation counters that override round-robin.
module issue_port_arbiter #(
  parameter int NUM_RS       = 4,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic [NUM_RS-1:0]         rs_valid_i,
  input  logic [NUM_RS*DATA_W-1:0]  rs_data_i,
  output logic [NUM_RS-1:0]         rs_ready_o,
  output logic                      fu_valid_o,
  input  logic                      fu_ready_i,
  output logic [DATA_W-1:0]         fu_data_o,
  output logic [$clog2(NUM_RS)-1:0] fu_src_o
);

  localparam int PTR_W = $clog2(NUM_RS);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_RS - 1);

  if (NUM_RS < 2 || STARVE_LIMIT < 1) begin : g_bad_cfg
    $error("issue_port_arbiter: NUM_RS must be >= 2 and STARVE_LIMIT >= 1");
  end

  logic              vld;
  logic [DATA_W-1:0] data;
  logic [PTR_W-1:0]  src;
  logic [PTR_W-1:0]  rr_ptr;

  logic              can_accept;
  logic              grant_en;
  logic              win_found;
  logic [PTR_W-1:0]  win_idx;
  logic [PTR_W:0]    scan;
  logic [DATA_W-1:0] win_data;
  logic              xfer_in;

`ifdef ISSUE_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
  logic [CNT_W-1:0] starve_cnt [NUM_RS];
`endif

  assign can_accept = ~vld | fu_ready_i;
  assign grant_en   = can_accept & ~flush_i & ~rst;

  // Scan rr_ptr, rr_ptr+1, ... with explicit wrap so NUM_RS need not be a power of two.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      scan = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (scan >= (PTR_W+1)'(NUM_RS)) scan = scan - (PTR_W+1)'(NUM_RS);
      if (!win_found && rs_valid_i[scan[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan[PTR_W-1:0];
      end
    end
`ifdef ISSUE_ARB_STARVE_EN
    // Descending loop so the lowest-index starving station is the one left standing.
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (rs_valid_i[i] && starve_cnt[i] == CNT_MAX) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(i);
      end
    end
`endif
  end

  always_comb begin
    rs_ready_o = '0;
    if (win_found && grant_en) rs_ready_o[win_idx] = 1'b1;
  end

  assign win_data = rs_data_i[win_idx*DATA_W +: DATA_W];
  assign xfer_in  = |(rs_ready_o & rs_valid_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld    <= 1'b0;
      data   <= '0;
      src    <= '0;
      rr_ptr <= '0;
    end else if (flush_i) begin
      vld <= 1'b0;
    end else if (xfer_in) begin
      vld    <= 1'b1;
      data   <= win_data;
      src    <= win_idx;
      rr_ptr <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
    end else if (vld && fu_ready_i) begin
      vld <= 1'b0;
    end
  end

`ifdef ISSUE_ARB_STARVE_EN
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_RS; i++) begin
      if (rst || flush_i || !rs_valid_i[i] || rs_ready_o[i]) begin
        starve_cnt[i] <= '0;
      end else if (starve_cnt[i] != CNT_MAX) begin
        starve_cnt[i] <= starve_cnt[i] + 1'b1;
      end
    end
  end
`endif

  assign fu_valid_o = vld;
  assign fu_data_o  = data;
  assign fu_src_o   = src;

endmodule

// File: doc/issue_port_arbiter.md
# issue_port_arbiter

Shares one functional-unit issue port between `NUM_RS` in-order reservation stations. Each cycle it grants at most one ready station using round-robin priority and captures the winning issue payload into a one-entry output register that drives the functional unit through a valid/ready handshake. It sits between the scheduler's reservation stations and a shared execution unit, such as the single memory or multiply/divide pipe.

## Interface
Parameters:
- `NUM_RS`, 4: number of requesting reservation stations; minimum 2, need not be a power of two.
- `DATA_W`, 64: width of one issue payload (packed issue base plus option code).
- `STARVE_LIMIT`, 8: wait-cycle threshold for the starvation override; only used with the macro (see Configuration).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush_i`  in  1  pipeline flush; discards buffered payload.
- `rs_valid_i`  in  `NUM_RS`  per-station issue request.
- `rs_data_i`  in  `NUM_RS`×`DATA_W`  per-station issue payload.
- `rs_ready_o`  out  `NUM_RS`  grant; one-hot or zero.
- `fu_valid_o`  out  1  output register holds a payload.
- `fu_ready_i`  in  1  functional unit accepts the payload.
- `fu_data_o`  out  `DATA_W`  buffered payload.
- `fu_src_o`  out  `$clog2(NUM_RS)`  index of the station that supplied `fu_data_o`.

## Operation
- State:
  - output register `{vld, data, src}`
  - round-robin pointer `rr_ptr` (`$clog2(NUM_RS)` bits)
  - starvation counters, only when the macro is defined.
- `can_accept = ~vld | fu_ready_i`. The output register is free, or it is being drained this cycle.
- Winner selection:
  - Search starts at the first `i` with `rs_valid_i[i]`, scanning `rr_ptr`, `rr_ptr+1`, … mod `NUM_RS`.
  - Wrap rule: index `NUM_RS-1` is followed by `0`.
- `rs_ready_o[winner] = can_accept & ~flush_i & ~rst`; all other bits are 0. No winner gives all zeros.
- Transfer in: when `rs_valid_i[w] & rs_ready_o[w]`, then `data<=rs_data_i[w]`, `src<=w`, `vld<=1`, and `rr_ptr<=(w==NUM_RS-1)?0:w+1`.
- Transfer out: when `vld & fu_ready_i` with no transfer in, `vld<=0`. `data` and `src` hold their values.
- Simultaneous drain and fill: the register takes the new payload, and `vld` stays 1.
- `rr_ptr` changes only on a transfer in.
- Stations must hold `rs_valid_i` and `rs_data_i` stable until granted. The arbiter never depends on stations deasserting valid.
- `flush_i`:
  - Next cycle `vld=0`.
  - No grant is issued in the flush cycle.
  - `rr_ptr` is preserved.
  - Starvation counters clear.
  - Flush overrides a same-cycle transfer in or out.
- `rst`:
  - `vld=0`, `data=0`, `src=0`, `rr_ptr=0`, and all counters 0.
  - Takes effect at the next edge, including mid-operation with `vld=1`.
  - `rs_ready_o=0` while `rst` is high.

## Timing
- Grant is combinational from `rs_valid_i`, `vld` and `fu_ready_i` in the same cycle.
- Latency is 1 cycle: a payload granted in cycle N appears on `fu_*` in cycle N+1.
- Throughput is 1 payload per cycle while `fu_ready_i=1`.
- `fu_valid_o`, `fu_data_o` and `fu_src_o` are registered only. `fu_valid_o` never drops without `fu_ready_i` or flush/reset.
- Backpressure: with `vld=1` and `fu_ready_i=0`, `rs_ready_o=0` and the register holds its contents.
- Reset values: `fu_valid_o=0`, `fu_data_o=0`, `fu_src_o=0`, `rs_ready_o=0`.

## Configuration
- `ISSUE_ARB_STARVE_EN` defined:
  - Each station has a saturating counter of `$clog2(STARVE_LIMIT+1)` bits.
  - The counter increments each cycle `rs_valid_i[i]` is high and the station is not granted.
  - It clears on grant, when `rs_valid_i[i]` is low, on flush, and on reset.
  - If any counter equals `STARVE_LIMIT`, the lowest-index such station wins, overriding round-robin. `rr_ptr` still updates to winner+1.
- `ISSUE_ARB_STARVE_EN` not defined: pure round-robin. Counters and `STARVE_LIMIT` logic are absent.

## Test plan
- Reset: hold `rst=1` 2 cycles with all `rs_valid_i=1` → `rs_ready_o=0`, `fu_valid_o=0`, `fu_src_o=0`. After release, first grant goes to station 0.
- Round-robin fairness: `NUM_RS=4`, all valid, `fu_ready_i=1` → `fu_src_o` sequence 0,1,2,3,0,… on consecutive cycles, one payload per cycle. Data matches the source station.
- Backpressure: fill the register from station 2, hold `fu_ready_i=0` 3 cycles → `rs_ready_o=0`, `fu_data_o` stable. Raise `fu_ready_i` → drains and refills in the same cycle, `fu_valid_o` stays 1.
- Wrap and sparse requests: only stations 1 and 3 valid, `rr_ptr=2` → grant 3, then 1 (wraps through 0), then 3.
- Flush: `vld=1` with station 0 requesting, assert `flush_i` with `fu_ready_i=1` → no grant that cycle, `fu_valid_o=0` next cycle, `rr_ptr` unchanged.
- Starvation (macro on, `STARVE_LIMIT=2`): `NUM_RS=4`, all valid, `fu_ready_i=1`, station 3 granted this cycle → grant sequence 0,1,2 then 3. Station 2 reaches limit 2 before its round-robin turn and is granted on the override path; counters reset on grant.
